// File: rtl/pcieifc_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// pcieifc_sram_fifo_ctrl
//
// First-word-fall-through FIFO controller wrapped around one external simple
// dual-port SRAM that has a registered (1-cycle) read port. A 2-entry prefetch
// buffer (head + skid) hides the read latency, so the block sustains one beat
// per cycle in and out.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   clr                      synchronous flush, beats the traffic in priority
//   in_valid/in_ready/in_data    write-side stream
//   out_valid/out_ready/out_data read-side stream; out_data comes from a register
//   count                    beats held: SRAM + in-flight read + prefetch buffer
//   sram_wea/addra/dina      SRAM write port (dina is in_data passed through)
//   sram_reb/addrb           SRAM read port
//   sram_doutb               SRAM read data, valid the cycle after sram_reb
// ---------------------------------------------------------------------------
module pcieifc_sram_fifo_ctrl #(
    parameter int DATAWIDTH = 269,
    parameter int ADDRWIDTH = 6,
    parameter int DEPTH     = 1 << ADDRWIDTH,
    parameter int CNTWIDTH  = ADDRWIDTH + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [CNTWIDTH-1:0]  count,
    output logic                 sram_wea,
    output logic [ADDRWIDTH-1:0] sram_addra,
    output logic [DATAWIDTH-1:0] sram_dina,
    output logic                 sram_reb,
    output logic [ADDRWIDTH-1:0] sram_addrb,
    input  logic [DATAWIDTH-1:0] sram_doutb
);

    localparam logic [ADDRWIDTH:0] DEPTH_U = (ADDRWIDTH + 1)'(DEPTH);

    logic [ADDRWIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDRWIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDRWIDTH:0]   sram_used_reg, sram_used_next;
    logic [1:0]           buf_cnt_reg, buf_cnt_next;
    logic                 rd_inflight_reg;
    logic [CNTWIDTH-1:0]  count_reg, count_next;
    logic [DATAWIDTH-1:0] head_reg, head_next;
    logic [DATAWIDTH-1:0] skid_reg, skid_next;

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] pending;

    // in_ready depends only on registered occupancy, so a read issued while
    // full frees a slot only from the next cycle on.
    assign in_ready  = (sram_used_reg < DEPTH_U) && !clr;
    // Gating with rst keeps the SRAM write strobe quiet while reset is held.
    assign push      = in_valid && in_ready && !rst;
    assign out_valid = (buf_cnt_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = head_reg;

    // Slots that will be occupied after this edge if nothing new is issued:
    // current buffer fill plus the read returning now, minus the beat leaving.
    assign pending = {1'b0, buf_cnt_reg} + {2'b00, rd_inflight_reg};
    assign issue   = (sram_used_reg != '0) && !clr && (pending < (3'd2 + {2'b00, pop}));

    assign sram_wea   = push;
    assign sram_addra = wr_ptr_reg;
    assign sram_dina  = in_data;
    assign sram_reb   = issue;
    assign sram_addrb = rd_ptr_reg;
    assign count      = count_reg;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg + ADDRWIDTH'(push);
        rd_ptr_next    = rd_ptr_reg + ADDRWIDTH'(issue);
        sram_used_next = sram_used_reg + (ADDRWIDTH + 1)'(push) - (ADDRWIDTH + 1)'(issue);
    end

    // Prefetch buffer. A returning read (rd_inflight_reg) lands in the first
    // free slot after any pop has been applied, which keeps beats in order.
    always_comb begin
        buf_cnt_next = buf_cnt_reg;
        head_next    = head_reg;
        skid_next    = skid_reg;
        case ({rd_inflight_reg, pop})
            2'b01: begin
                head_next    = skid_reg;
                buf_cnt_next = buf_cnt_reg - 2'd1;
            end
            2'b10: begin
                if (buf_cnt_reg == 2'd0) begin
                    head_next = sram_doutb;
                end else begin
                    skid_next = sram_doutb;
                end
                buf_cnt_next = buf_cnt_reg + 2'd1;
            end
            2'b11: begin
                if (buf_cnt_reg == 2'd1) begin
                    head_next = sram_doutb;
                end else begin
                    head_next = skid_reg;
                    skid_next = sram_doutb;
                end
            end
            default: begin
            end
        endcase
    end

    // count tracks the state that will exist after this edge, so it always
    // agrees with the other registered counters.
    always_comb begin
        count_next = CNTWIDTH'(sram_used_next) + CNTWIDTH'(buf_cnt_next) + CNTWIDTH'(issue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            sram_used_reg   <= '0;
            buf_cnt_reg     <= '0;
            rd_inflight_reg <= 1'b0;
            count_reg       <= '0;
        end else if (clr) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            sram_used_reg   <= '0;
            buf_cnt_reg     <= '0;
            rd_inflight_reg <= 1'b0;
            count_reg       <= '0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            sram_used_reg   <= sram_used_next;
            buf_cnt_reg     <= buf_cnt_next;
            rd_inflight_reg <= issue;
            count_reg       <= count_next;
        end
    end

    // Payload registers carry no reset: their contents are ignored whenever
    // buf_cnt_reg says the slot is empty.
    always_ff @(posedge clk) begin
        head_reg <= head_next;
        skid_reg <= skid_next;
    end

endmodule

// File: tb/tb_pcieifc_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcieifc_sram_fifo_ctrl
//
// Self-checking bench for pcieifc_sram_fifo_ctrl with a behavioural SRAM
// (registered read). A table of per-cycle vectors covers single-beat latency
// and short back-to-back traffic; hand-written sequences cover fill to full,
// streaming with pointer wrap, random backpressure, clr and async reset.
// ---------------------------------------------------------------------------
module tb_pcieifc_sram_fifo_ctrl;

    localparam int DW    = 269;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 2;

    typedef logic [299:0] w_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          sram_wea;
    logic [AW-1:0] sram_addra;
    logic [DW-1:0] sram_dina;
    logic          sram_reb;
    logic [AW-1:0] sram_addrb;
    logic [DW-1:0] sram_doutb = '0;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pcieifc_sram_fifo_ctrl #(
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .sram_wea   (sram_wea),
        .sram_addra (sram_addra),
        .sram_dina  (sram_dina),
        .sram_reb   (sram_reb),
        .sram_addrb (sram_addrb),
        .sram_doutb (sram_doutb)
    );

    // Behavioural SRAM: write on the edge, registered read.
    always @(posedge clk) begin
        if (sram_wea) mem[sram_addra] <= sram_dina;
        if (sram_reb) sram_doutb <= mem[sram_addrb];
    end

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic        in_valid;
        logic [15:0] in_data;
        logic        out_ready;
        logic        e_in_ready;
        logic        e_out_valid;
        logic [15:0] e_out_data;
        int          e_count;
        logic        e_wea;
        int          e_addra;
        logic        e_reb;
        int          e_addrb;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int            acc;
        int            sent;
        int            recv;
        int            gaps;
        int            t;
        int            max_cnt;
        bit            started;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] q [$];

        //          iv  din     ordy ird ov  dout    cnt wea addra reb addrb
        vecs[0]  = '{1'b1, 16'h1A5, 1'b1, 1'b1, 1'b0, 16'h0,   0, 1'b1, 0, 1'b0, 0};
        vecs[1]  = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b0, 16'h0,   1, 1'b0, 1, 1'b1, 0};
        vecs[2]  = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b0, 16'h0,   1, 1'b0, 1, 1'b0, 1};
        vecs[3]  = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b1, 16'h1A5, 1, 1'b0, 1, 1'b0, 1};
        vecs[4]  = '{1'b1, 16'h2,   1'b1, 1'b1, 1'b0, 16'h0,   0, 1'b1, 1, 1'b0, 1};
        vecs[5]  = '{1'b1, 16'h3,   1'b1, 1'b1, 1'b0, 16'h0,   1, 1'b1, 2, 1'b1, 1};
        vecs[6]  = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b0, 16'h0,   2, 1'b0, 3, 1'b1, 2};
        vecs[7]  = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b1, 16'h2,   2, 1'b0, 3, 1'b0, 3};
        vecs[8]  = '{1'b0, 16'h0,   1'b0, 1'b1, 1'b1, 16'h3,   1, 1'b0, 3, 1'b0, 3};
        vecs[9]  = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b1, 16'h3,   1, 1'b0, 3, 1'b0, 3};
        vecs[10] = '{1'b0, 16'h0,   1'b1, 1'b1, 1'b0, 16'h0,   0, 1'b0, 3, 1'b0, 3};

        // ---------------- reset state ----------------
        next_cycle();
        chk("rst_in_ready",  w_t'(in_ready),  w_t'(1));
        chk("rst_out_valid", w_t'(out_valid), w_t'(0));
        chk("rst_count",     w_t'(count),     w_t'(0));
        chk("rst_wea",       w_t'(sram_wea),  w_t'(0));
        chk("rst_reb",       w_t'(sram_reb),  w_t'(0));
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 11; i++) begin
            in_valid  = vecs[i].in_valid;
            in_data   = '0;
            in_data[15:0] = vecs[i].in_data;
            out_ready = vecs[i].out_ready;
            #1;
            chk($sformatf("v%0d_in_ready", i),  w_t'(in_ready),   w_t'(vecs[i].e_in_ready));
            chk($sformatf("v%0d_out_valid", i), w_t'(out_valid),  w_t'(vecs[i].e_out_valid));
            if (vecs[i].e_out_valid)
                chk($sformatf("v%0d_out_data", i), w_t'(out_data), w_t'(vecs[i].e_out_data));
            chk($sformatf("v%0d_count", i),     w_t'(count),      w_t'(vecs[i].e_count));
            chk($sformatf("v%0d_wea", i),       w_t'(sram_wea),   w_t'(vecs[i].e_wea));
            chk($sformatf("v%0d_addra", i),     w_t'(sram_addra), w_t'(vecs[i].e_addra));
            if (vecs[i].e_wea)
                chk($sformatf("v%0d_dina", i),  w_t'(sram_dina),  w_t'(vecs[i].in_data));
            chk($sformatf("v%0d_reb", i),       w_t'(sram_reb),   w_t'(vecs[i].e_reb));
            chk($sformatf("v%0d_addrb", i),     w_t'(sram_addrb), w_t'(vecs[i].e_addrb));
            @(negedge clk);
        end
        in_valid = 1'b0;
        $display("table vectors done: %0d checks so far", n_checks);

        // ---------------- fill to full, then drain ----------------
        out_ready = 1'b0;
        acc = 0;
        t = 0;
        in_valid = 1'b1;
        in_data = DW'(100);
        #1;
        while (in_ready && t < 200) begin
            acc++;
            next_cycle();
            in_data = DW'(100 + acc);
            #0;
            t++;
        end
        chk("full_accepts", w_t'(acc), w_t'(DEPTH + 2));
        chk("full_count", w_t'(count), w_t'(DEPTH + 2));
        chk("full_in_ready", w_t'(in_ready), w_t'(0));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            #0;
            chk($sformatf("drain_valid_%0d", i), w_t'(out_valid), w_t'(1));
            chk($sformatf("drain_data_%0d", i), w_t'(out_data), w_t'(100 + i));
            next_cycle();
        end
        chk("drain_empty", w_t'(out_valid), w_t'(0));
        chk("drain_count", w_t'(count), w_t'(0));
        $display("fill/drain done: accepted %0d", acc);

        // ---------------- 200-beat streaming ----------------
        sent = 0;
        recv = 0;
        gaps = 0;
        started = 1'b0;
        t = 0;
        out_ready = 1'b1;
        while (recv < 200 && t < 1000) begin
            in_valid = (sent < 200);
            in_data  = DW'(sent);
            #1;
            if (in_valid && !in_ready) gaps++;
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                started = 1'b1;
                chk($sformatf("stream_data_%0d", recv), w_t'(out_data), w_t'(recv));
                recv++;
            end else if (started) begin
                gaps++;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        chk("stream_recv", w_t'(recv), w_t'(200));
        chk("stream_gaps", w_t'(gaps), w_t'(0));
        $display("stream done: %0d beats, %0d gaps", recv, gaps);

        // ---------------- random backpressure ----------------
        sent = 0;
        recv = 0;
        t = 0;
        max_cnt = 0;
        q.delete();
        while (recv < 300 && t < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 300);
            in_data   = DW'(1000 + sent);
            #1;
            chk($sformatf("rand_count_c%0d", t), w_t'(count), w_t'(sent - recv));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                exp_d = q.pop_front();
                chk($sformatf("rand_data_%0d", recv), w_t'(out_data), w_t'(exp_d));
                recv++;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        chk("rand_recv", w_t'(recv), w_t'(300));
        chk("rand_max_le_66", w_t'(max_cnt <= DEPTH + 2), w_t'(1));
        $display("random backpressure done: %0d beats, max count %0d", recv, max_cnt);

        // ---------------- clr ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h500 + i);
            #1;
            chk($sformatf("clr_fill_rdy_%0d", i), w_t'(in_ready), w_t'(1));
            @(negedge clk);
        end
        clr = 1'b1;
        in_data = DW'(16'hEE);
        #1;
        chk("clr_in_ready", w_t'(in_ready), w_t'(0));
        chk("clr_wea", w_t'(sram_wea), w_t'(0));
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_count", w_t'(count), w_t'(0));
        chk("clr_out_valid", w_t'(out_valid), w_t'(0));
        @(negedge clk);
        in_valid = 1'b1;
        in_data = DW'(16'h55);
        out_ready = 1'b1;
        #1;
        chk("clr_post_wea", w_t'(sram_wea), w_t'(1));
        chk("clr_post_addra", w_t'(sram_addra), w_t'(0));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        t = 0;
        while (!out_valid && t < 20) begin
            next_cycle();
            t++;
        end
        chk("clr_post_valid", w_t'(out_valid), w_t'(1));
        chk("clr_post_data", w_t'(out_data), w_t'(16'h55));
        next_cycle();
        chk("clr_post_empty", w_t'(out_valid), w_t'(0));
        $display("clr sequence done");

        // ---------------- async reset mid-stream ----------------
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = DW'(16'h200 + i);
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", w_t'(out_valid), w_t'(0));
        chk("arst_count", w_t'(count), w_t'(0));
        chk("arst_in_ready", w_t'(in_ready), w_t'(1));
        chk("arst_wea", w_t'(sram_wea), w_t'(0));
        chk("arst_reb", w_t'(sram_reb), w_t'(0));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(16'h3C);
        #1;
        chk("arst_post_addra", w_t'(sram_addra), w_t'(0));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        t = 0;
        while (!out_valid && t < 20) begin
            next_cycle();
            t++;
        end
        chk("arst_post_valid", w_t'(out_valid), w_t'(1));
        chk("arst_post_data", w_t'(out_data), w_t'(16'h3C));
        next_cycle();
        chk("arst_post_empty", w_t'(out_valid), w_t'(0));
        $display("async reset sequence done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
